// File: rtl/eth_crc32_engine.sv
// Ethernet CRC-32 engine (poly 0x04C11DB7, MSB-first per word) for the MII/FIFO path.
// Handles Sof/Eof framing. Generate mode appends a serialised FCS after the payload.
// Check mode produces a one-shot good/bad verdict against the magic residue.
module eth_crc32_engine #(
    parameter int          DATA_W  = 4,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mode,
    input  logic              Sof,
    input  logic              Eof,
    input  logic              DataValid,
    input  logic [DATA_W-1:0] DataIn,
    output logic              Busy,
    output logic [31:0]       Crc,
    output logic [DATA_W-1:0] FcsOut,
    output logic              FcsValid,
    output logic              FcsLast,
    output logic              CheckDone,
    output logic              CrcError
);
    localparam int               N        = 32 / DATA_W;
    localparam int               CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
    localparam logic [31:0]      POLY     = 32'h04C11DB7;

    generate
        if (DATA_W != 4 && DATA_W != 8) begin : g_bad_width
            $error("eth_crc32_engine: DATA_W must be 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, APPEND} state_t;

    // Advance the CRC over one word, DataIn[DATA_W-1] first.
    function automatic logic [31:0] crc_update(input logic [31:0] crc_in,
                                               input logic [DATA_W-1:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        // NOTE: blocking assignments here are intentional; each bit's result feeds the next bit
        // combinationally within the same word.
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = data[i] ^ c[31];
            c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return c;
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic              mode_q, mode_d;
    logic [31:0]       fcs_sh_q, fcs_sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] fcs_out_q, fcs_out_d;
    logic              fcs_valid_q, fcs_valid_d;
    logic              fcs_last_q, fcs_last_d;
    logic              check_done_q, check_done_d;
    logic              crc_error_q, crc_error_d;

    logic              accept;
    logic              frame_mode;
    logic [31:0]       word_crc;
    logic [31:0]       fcs_word;

    // Next-state and next-output logic for the frame FSM.
    always_comb begin
        // NOTE: every signal driven here gets a default first.
        // That way no path leaves a value unassigned, and no latch is inferred.
        state_d      = state_q;
        crc_d        = crc_q;
        mode_d       = mode_q;
        fcs_sh_d     = fcs_sh_q;
        cnt_d        = cnt_q;
        fcs_out_d    = fcs_out_q;
        fcs_valid_d  = 1'b0;
        fcs_last_d   = 1'b0;
        check_done_d = 1'b0;
        crc_error_d  = crc_error_q;

        // A Sof word always starts from the preset and re-samples Mode, even mid-frame.
        frame_mode = Sof ? Mode : mode_q;
        word_crc   = crc_update(Sof ? INIT : crc_q, DataIn);
        fcs_word   = ~word_crc;
        accept     = DataValid && (Sof || state_q == ACCUM);

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    crc_d   = word_crc;
                    mode_d  = frame_mode;
                    state_d = ACCUM;
                    if (Eof) begin
                        if (frame_mode) begin
                            // First FCS word goes out next cycle; the rest queue in the shifter.
                            fcs_out_d   = fcs_word[31 -: DATA_W];
                            fcs_sh_d    = fcs_word << DATA_W;
                            fcs_valid_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = APPEND;
                        end else begin
                            check_done_d = 1'b1;
                            crc_error_d  = (word_crc != RESIDUE);
                            state_d      = IDLE;
                        end
                    end
                end
            end
            APPEND: begin
                // cnt_q is the index of the FCS word currently on FcsOut.
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    fcs_out_d   = fcs_sh_q[31 -: DATA_W];
                    fcs_sh_d    = fcs_sh_q << DATA_W;
                    fcs_valid_d = 1'b1;
                    fcs_last_d  = (cnt_d == LAST_IDX);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register state, CRC and all outputs; synchronous active-high reset.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments make every register sample the pre-edge values.
        if (Reset) begin
            state_q      <= IDLE;
            crc_q        <= INIT;
            mode_q       <= 1'b0;
            fcs_sh_q     <= '0;
            cnt_q        <= '0;
            fcs_out_q    <= '0;
            fcs_valid_q  <= 1'b0;
            fcs_last_q   <= 1'b0;
            check_done_q <= 1'b0;
            crc_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            mode_q       <= mode_d;
            fcs_sh_q     <= fcs_sh_d;
            cnt_q        <= cnt_d;
            fcs_out_q    <= fcs_out_d;
            fcs_valid_q  <= fcs_valid_d;
            fcs_last_q   <= fcs_last_d;
            check_done_q <= check_done_d;
            crc_error_q  <= crc_error_d;
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Crc       = crc_q;
    assign FcsOut    = fcs_out_q;
    assign FcsValid  = fcs_valid_q;
    assign FcsLast   = fcs_last_q;
    assign CheckDone = check_done_q;
    assign CrcError  = crc_error_q;

endmodule

// File: tb/tb_eth_crc32_engine.sv
// Self-checking bench for eth_crc32_engine at DATA_W=4 and DATA_W=8.
// The reference CRC is computed as a polynomial remainder by long division over GF(2).
module tb_eth_crc32_engine;
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;

    typedef logic [3:0] nibq_t[$];
    typedef logic [7:0] byteq_t[$];
    typedef bit         bitq_t[$];

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic        mode4, sof4, eof4, valid4;
    logic [3:0]  din4;
    logic        busy4, fcs_valid4, fcs_last4, check_done4, crc_error4;
    logic [31:0] crc4;
    logic [3:0]  fcs_out4;

    logic        mode8, sof8, eof8, valid8;
    logic [7:0]  din8;
    logic        busy8, fcs_valid8, fcs_last8, check_done8, crc_error8;
    logic [31:0] crc8;
    logic [7:0]  fcs_out8;

    eth_crc32_engine #(.DATA_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Mode(mode4), .Sof(sof4), .Eof(eof4),
        .DataValid(valid4), .DataIn(din4), .Busy(busy4), .Crc(crc4),
        .FcsOut(fcs_out4), .FcsValid(fcs_valid4), .FcsLast(fcs_last4),
        .CheckDone(check_done4), .CrcError(crc_error4)
    );

    eth_crc32_engine #(.DATA_W(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .Mode(mode8), .Sof(sof8), .Eof(eof8),
        .DataValid(valid8), .DataIn(din8), .Busy(busy8), .Crc(crc8),
        .FcsOut(fcs_out8), .FcsValid(fcs_valid8), .FcsLast(fcs_last8),
        .CheckDone(check_done8), .CrcError(crc_error8)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Remainder of (INIT * x^L + M(x) * x^32) mod G(x), with M taken MSB first.
    function automatic logic [31:0] model_crc(input bitq_t bits);
        bit [32:0]   g;
        bit [31:0]   init;
        bitq_t       a;
        logic [31:0] r;
        int          len;
        g    = 33'h1_04C1_1DB7;
        init = 32'hFFFF_FFFF;
        len  = bits.size();
        a    = bits;
        for (int j = 0; j < 32; j++) a.push_back(1'b0);
        for (int j = 0; j < 32; j++) a[j] = a[j] ^ init[31-j];
        for (int i = 0; i < len; i++)
            if (a[i]) for (int k = 0; k <= 32; k++) a[i+k] = a[i+k] ^ g[32-k];
        for (int j = 0; j < 32; j++) r[31-j] = a[len+j];
        return r;
    endfunction

    function automatic bitq_t nib_bits(input nibq_t p);
        bitq_t q;
        foreach (p[i]) for (int b = 3; b >= 0; b--) q.push_back(p[i][b]);
        return q;
    endfunction

    function automatic nibq_t bytes_to_nibs(input byteq_t p);
        nibq_t q;
        foreach (p[i]) begin
            q.push_back(p[i][7:4]);
            q.push_back(p[i][3:0]);
        end
        return q;
    endfunction

    function automatic nibq_t with_fcs(input nibq_t p, input logic [31:0] fcs);
        nibq_t q;
        q = p;
        for (int j = 7; j >= 0; j--) q.push_back(fcs[j*4 +: 4]);
        return q;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle4();
        sof4 = 1'b0; eof4 = 1'b0; valid4 = 1'b0; din4 = '0;
    endtask

    task automatic idle8();
        sof8 = 1'b0; eof8 = 1'b0; valid8 = 1'b0; din8 = '0;
    endtask

    task automatic drive4(input logic s, input logic e, input logic v, input logic m, input logic [3:0] d);
        sof4 = s; eof4 = e; valid4 = v; mode4 = m; din4 = d;
        step();
    endtask

    // Mode is inverted after the Sof word, so only the latched value may matter.
    task automatic send4(input nibq_t p, input logic m);
        for (int i = 0; i < p.size(); i++)
            drive4(i == 0, i == p.size() - 1, 1'b1, (i == 0) ? m : ~m, p[i]);
        idle4();
    endtask

    task automatic gen4(input nibq_t p, input bit junk, input int rst_at, output logic [31:0] fcs);
        logic [31:0] exp_crc;
        exp_crc = model_crc(nib_bits(p));
        fcs = '0;
        send4(p, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check("gen4_valid", fcs_valid4, 1'b1);
            check("gen4_last", fcs_last4, k == 7);
            check("gen4_busy", busy4, 1'b1);
            check("gen4_crc_hold", crc4, exp_crc);
            fcs = {fcs[27:0], fcs_out4};
            if (k == rst_at) begin
                Reset = 1'b1;
                step();
                Reset = 1'b0;
                check("rst_app_valid", fcs_valid4, 1'b0);
                check("rst_app_busy", busy4, 1'b0);
                check("rst_app_crc", crc4, 32'hFFFFFFFF);
                check("rst_app_done", check_done4, 1'b0);
                return;
            end
            if (junk && k < 7) begin
                valid4 = 1'b1; sof4 = 1'($urandom); eof4 = 1'($urandom);
                mode4 = 1'($urandom); din4 = 4'($urandom);
            end else begin
                idle4();
            end
            step();
        end
        check("gen4_end_valid", fcs_valid4, 1'b0);
        check("gen4_end_busy", busy4, 1'b0);
        check("gen4_fcs", fcs, ~exp_crc);
    endtask

    task automatic chk4(input nibq_t p, input bit exp_err);
        logic [31:0] exp_crc;
        exp_crc = model_crc(nib_bits(p));
        send4(p, 1'b0);
        check("chk4_done", check_done4, 1'b1);
        check("chk4_err", crc_error4, exp_err);
        check("chk4_crc", crc4, exp_crc);
        step();
        check("chk4_done_pulse", check_done4, 1'b0);
        check("chk4_err_hold", crc_error4, exp_err);
        check("chk4_idle", busy4, 1'b0);
    endtask

    task automatic gen8(input byteq_t p, output logic [31:0] fcs);
        logic [31:0] exp_crc;
        exp_crc = model_crc(nib_bits(bytes_to_nibs(p)));
        fcs = '0;
        for (int i = 0; i < p.size(); i++) begin
            sof8 = (i == 0); eof8 = (i == p.size() - 1); valid8 = 1'b1;
            mode8 = (i == 0); din8 = p[i];
            step();
        end
        idle8();
        for (int k = 0; k < 4; k++) begin
            check("gen8_valid", fcs_valid8, 1'b1);
            check("gen8_last", fcs_last8, k == 3);
            check("gen8_crc_hold", crc8, exp_crc);
            fcs = {fcs[23:0], fcs_out8};
            step();
        end
        check("gen8_end_valid", fcs_valid8, 1'b0);
        check("gen8_end_busy", busy8, 1'b0);
        check("gen8_fcs", fcs, ~exp_crc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nibq_t       pay, frame, bad, one, part;
        byteq_t      bytes;
        logic [31:0] fcs, fcs4, fcs8;

        Reset = 1'b1; mode4 = 1'b0; mode8 = 1'b0;
        idle4(); idle8();
        step(); step();
        Reset = 1'b0;

        // Reset state
        check("rst_crc4", crc4, 32'hFFFFFFFF);
        check("rst_crc8", crc8, 32'hFFFFFFFF);
        check("rst_busy4", busy4, 1'b0);
        check("rst_fcs_out4", fcs_out4, 4'h0);
        check("rst_flags4", {fcs_valid4, fcs_last4, check_done4, crc_error4}, 4'b0000);
        check("rst_flags8", {busy8, fcs_valid8, fcs_last8, check_done8, crc_error8}, 5'b00000);

        // Loopback with a 120-nibble payload
        for (int i = 0; i < 120; i++) pay.push_back(4'($urandom));
        gen4(pay, 1'b0, -1, fcs);
        frame = with_fcs(pay, fcs);
        chk4(frame, 1'b0);
        check("loop_residue", crc4, RESIDUE);

        // Words in IDLE without Sof are ignored
        for (int i = 0; i < 4; i++) drive4(1'b0, 1'b1, 1'b1, 1'b0, 4'($urandom));
        idle4();
        step();
        check("idle_ign_crc", crc4, RESIDUE);
        check("idle_ign_busy", busy4, 1'b0);
        check("idle_ign_done", check_done4, 1'b0);

        // Corrupted frame: bit 0 of nibble 17 flipped
        bad = frame;
        bad[17] = bad[17] ^ 4'h1;
        chk4(bad, 1'b1);
        check("bad_crc_ne_res", crc4 != RESIDUE, 1'b1);

        // Width equivalence: 64 bytes at DATA_W=8 vs the same bits as nibbles at DATA_W=4
        for (int i = 0; i < 64; i++) bytes.push_back(8'($urandom));
        gen4(bytes_to_nibs(bytes), 1'b0, -1, fcs4);
        gen8(bytes, fcs8);
        check("width_fcs_bits", fcs8, ~model_crc(nib_bits(bytes_to_nibs(bytes))));

        // One-word frame: Sof = Eof, nibble 0xF, generate mode
        one.push_back(4'hF);
        gen4(one, 1'b0, -1, fcs);

        // Restart: a generate frame abandoned by a new Sof, then a good check frame
        for (int i = 0; i < 10; i++) part.push_back(4'($urandom));
        for (int i = 0; i < part.size(); i++) begin
            drive4(i == 0, 1'b0, 1'b1, 1'b1, part[i]);
            check("restart_no_done", check_done4, 1'b0);
            check("restart_no_fcs", fcs_valid4, 1'b0);
        end
        chk4(frame, 1'b0);

        // Junk Sof/Eof/DataValid during APPEND must not disturb Crc or the FCS
        pay.delete();
        for (int i = 0; i < 40; i++) pay.push_back(4'($urandom));
        gen4(pay, 1'b1, -1, fcs);
        chk4(with_fcs(pay, fcs), 1'b0);

        // Reset on the third FCS word, then a clean loopback
        gen4(pay, 1'b0, 2, fcs);
        pay.delete();
        for (int i = 0; i < 30; i++) pay.push_back(4'($urandom));
        gen4(pay, 1'b0, -1, fcs);
        chk4(with_fcs(pay, fcs), 1'b0);
        check("post_rst_residue", crc4, RESIDUE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/eth_crc32_engine.md
Name: eth_crc32_engine

Overview:
- Parametrised Ethernet CRC-32 engine (polynomial 0x04C11DB7) for the 10/100M MAC FIFO path.
- Processes DATA_W bits per clock and generalises the fixed 4-bit CRC block.
- Adds frame-level control: Sof/Eof framing, a runtime generate/check mode, serialised FCS emission in generate mode, and a one-shot check verdict in check mode.
- Sits between the MII nibble/byte datapath and the TX/RX FIFO controllers.

Parameters:
- DATA_W, 4: bits per word; legal values 4 and 8 (any other value is a synthesis error). Must divide 32.
- INIT, 32'hFFFFFFFF: CRC preset loaded at start of frame.
- RESIDUE, 32'hC704DD7B: magic remainder that marks a good frame in check mode.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Mode  in  1  0 = check, 1 = generate; sampled only on an accepted Sof word.
- Sof  in  1  first word of frame; qualified by DataValid.
- Eof  in  1  last word of frame (last payload word, or last FCS word in check mode); qualified by DataValid.
- DataValid  in  1  DataIn valid this cycle.
- DataIn  in  DATA_W  frame data word.
- Busy  out  1  high in ACCUM and APPEND.
- Crc  out  32  current CRC register.
- FcsOut  out  DATA_W  FCS word (generate mode).
- FcsValid  out  1  FcsOut valid.
- FcsLast  out  1  last FCS word.
- CheckDone  out  1  one-cycle pulse when a check verdict is ready.
- CrcError  out  1  verdict; 1 = mismatch; held until the next CheckDone.

Behaviour:
- Reset (synchronous) sets: state IDLE; Crc = INIT; FcsOut = 0; FcsValid = 0; FcsLast = 0; CheckDone = 0; CrcError = 0; Busy = 0.
- CRC update rule:
  - Per bit: fb = d ^ Crc[31]; Crc = {Crc[30:0],1'b0} ^ (fb ? 32'h04C11DB7 : 0).
  - Within a word, DataIn[DATA_W-1] is processed first.
  - With DATA_W=4 this matches the existing nibble CRC bit-for-bit.
  - One 8-bit word {A,B} equals nibble A followed by nibble B.
- Update only happens on cycles with DataValid in IDLE (with Sof) or ACCUM. Otherwise Crc holds.
- IDLE:
  - DataValid & Sof: the word is CRC'd starting from INIT (not the stale register). Latch Mode. Go to ACCUM.
  - If Eof is also set, it is a one-word frame and the ACCUM Eof handling below applies in this same cycle.
  - DataValid without Sof is ignored; Eof without Sof is ignored.
- ACCUM:
  - Words are CRC'd back to back; no bubbles are required.
  - DataValid & Sof: restart the frame (preset to INIT, re-latch Mode); the old frame is discarded with no verdict and no FCS.
  - DataValid & Eof:
    - Check mode: next Crc = update(word). Compare that value with RESIDUE. Next cycle: CheckDone = 1 and CrcError = (value != RESIDUE). Go to IDLE.
    - Generate mode: latch F = ~update(word) into an FCS shift register. Go to APPEND.
- APPEND (generate mode only):
  - Emits N = 32/DATA_W words on consecutive cycles, starting the cycle after Eof.
  - Word k = F[31-k*DATA_W -: DATA_W], with the MSB word first.
  - FcsValid = 1 for N cycles; FcsLast = 1 on word N-1.
  - Then go to IDLE. Crc holds the un-inverted final CRC throughout.
  - DataValid/Sof/Eof during APPEND are ignored; Busy = 1. Upstream must wait for Busy = 0.
- Loopback property: feeding the payload followed by the N emitted FCS words into a check-mode frame yields Crc == RESIDUE and CrcError = 0.
- Outputs are registered. FcsValid, FcsLast and CheckDone are 0 whenever not asserted as described above.
- Reset asserted mid-frame or mid-APPEND: the next cycle is the full reset state. No partial FCS and no CheckDone is produced.
- Counter: log2(N)-bit counter, where N = 8 for DATA_W=4 and N = 4 for DATA_W=8. No wrap beyond N-1.

Test Plan:
- Loopback, DATA_W=4: generate-mode frame of 120 random nibbles; capture the 8 FcsOut nibbles; replay payload plus FCS in check mode. Expect CheckDone one cycle after Eof, CrcError = 0, Crc = 32'hC704DD7B.
- Corrupted frame: same stimulus with bit 0 of nibble 17 flipped. Expect CrcError = 1 and Crc != 32'hC704DD7B.
- Width equivalence: identical 64-byte frame run at DATA_W=8 and DATA_W=4, with the byte split high nibble first. Expect identical final Crc and identical FCS bit stream. FcsValid lasts 4 vs 8 cycles; FcsLast is on the 4th vs 8th cycle.
- One-word frame: Sof = Eof = DataValid = 1 with DataIn = 0xF (DATA_W=4), generate mode. Expect Busy = 1 next cycle, then 8 FcsValid cycles; F must equal the golden-model ~CRC of that single nibble starting from INIT.
- Restart and ignore: Sof mid-ACCUM followed by a valid frame gives a verdict for the second frame only. DataValid words presented during APPEND do not change Crc or the FCS words.
- Reset mid-APPEND: assert Reset on the 3rd FcsValid cycle. The next cycle shows FcsValid = 0, Busy = 0, Crc = 32'hFFFFFFFF. A subsequent loopback frame passes.
